// File: rtl/can_bus_monitor_pkg.sv
// Shared encodings and constants for the CAN bus monitor.
package can_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF
    } can_state_e;

    localparam logic [14:0] CRC15_POLY = 15'h4599;

    localparam int ID_LEN      = 11;
    localparam int DLC_LEN     = 4;
    localparam int CTRL_LEN    = 2 + DLC_LEN;   // IDE, r0, DLC
    localparam int CRC_LEN     = 15;
    localparam int EOF_LEN     = 7;
    localparam int IDLE_LEN    = 11;
    localparam int STUFF_LIMIT = 5;

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        return fb ? ({crc[13:0], 1'b0} ^ CRC15_POLY) : {crc[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/can_bus_monitor_bit_timing.sv
// Free-running CAN bit-time counter with hard sync; emits one sample strobe per bit.
module can_bit_timing #(
    parameter int TBIT      = 100,
    parameter int SAMPLE_PT = 70
) (
    input  logic GCLK,
    input  logic RES,
    input  logic bus,
    input  logic hsync_en,
    output logic sample,
    output logic sbit
);

    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_q;
    logic          hsync;
    logic          sample_q, sample_d;
    logic          sbit_q, sbit_d;

    assign hsync = hsync_en && bus_q && !bus;

    // A strobe coinciding with the sync edge would sample the SOF twice, so it is dropped.
    always_comb begin
        if (hsync) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CW'(TBIT - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        sample_d = (cnt_q == CW'(SAMPLE_PT)) && !hsync;
        sbit_d   = sample_d ? bus : sbit_q;
    end

    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) begin
            cnt_q    <= '0;
            bus_q    <= 1'b1;
            sample_q <= 1'b0;
            sbit_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            bus_q    <= bus;
            sample_q <= sample_d;
            sbit_q   <= sbit_d;
        end
    end

    assign sample = sample_q;
    assign sbit   = sbit_q;

endmodule

// File: rtl/can_bus_monitor.sv
// Wired-AND CAN bus plus passive standard-frame monitor: destuffing, CRC-15,
// form checks, per-node arbitration loss and double-buffered field capture.
module can_bus_monitor
    import can_pkg::*;
#(
    parameter int NODES     = 2,
    parameter int TBIT      = 100,
    parameter int SAMPLE_PT = 70,
    parameter int FCNT_W    = 16
) (
    input  logic              GCLK,
    input  logic              RES,
    input  logic [NODES-1:0]  TXD,
    output logic              CAN_BUS,
    output logic              bus_idle,
    output logic [10:0]       rx_id,
    output logic              rx_rtr,
    output logic [3:0]        rx_dlc,
    output logic [63:0]       rx_data,
    output logic              rx_ack,
    output logic              frame_valid,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_stuff,
    output logic              err_crc,
    output logic              err_form,
    output logic [NODES-1:0]  arb_lost
);

    logic sample, sbit, in_stuff, take;
    logic [3:0] dlc_next;

    can_state_e        state_q, state_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        run_q, run_d;
    logic              last_q, last_d;
    logic [14:0]       crc_q, crc_d, crc_rx_q, crc_rx_d;
    logic [10:0]       id_sh_q, id_sh_d, rx_id_q, rx_id_d;
    logic              rtr_sh_q, rtr_sh_d, rx_rtr_q, rx_rtr_d;
    logic [3:0]        dlc_sh_q, dlc_sh_d, rx_dlc_q, rx_dlc_d;
    logic [63:0]       data_sh_q, data_sh_d, rx_data_q, rx_data_d;
    logic              ack_sh_q, ack_sh_d, rx_ack_q, rx_ack_d;
    logic [6:0]        data_len_q, data_len_d;
    logic [NODES-1:0]  arb_lost_q, arb_lost_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_stuff_q, err_stuff_d, err_crc_q, err_crc_d, err_form_q, err_form_d;

    assign CAN_BUS  = &TXD;
    assign bus_idle = (state_q == ST_IDLE);
    assign in_stuff = state_q inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC};

    can_bit_timing #(
        .TBIT      (TBIT),
        .SAMPLE_PT (SAMPLE_PT)
    ) u_bit_timing (
        .GCLK     (GCLK),
        .RES      (RES),
        .bus      (CAN_BUS),
        .hsync_en (bus_idle),
        .sample   (sample),
        .sbit     (sbit)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        run_d         = run_q;
        last_d        = last_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        id_sh_d       = id_sh_q;
        rtr_sh_d      = rtr_sh_q;
        dlc_sh_d      = dlc_sh_q;
        data_sh_d     = data_sh_q;
        ack_sh_d      = ack_sh_q;
        data_len_d    = data_len_q;
        arb_lost_d    = arb_lost_q;
        rx_id_d       = rx_id_q;
        rx_rtr_d      = rx_rtr_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_ack_d      = rx_ack_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = 1'b0;
        err_stuff_d   = 1'b0;
        err_crc_d     = 1'b0;
        err_form_d    = 1'b0;
        dlc_next      = {dlc_sh_q[2:0], sbit};
        take          = sample;

        // Destuffer: a stuff bit is consumed here and never reaches field decode or CRC.
        if (sample && in_stuff) begin
            if (run_q == 3'(STUFF_LIMIT)) begin
                take = 1'b0;
                if (sbit == last_q) begin
                    err_stuff_d = 1'b1;
                    state_d     = ST_WAIT_IDLE;
                    bit_cnt_d   = '0;
                end else begin
                    run_d  = 3'd1;
                    last_d = sbit;
                end
            end else begin
                run_d  = (sbit == last_q) ? run_q + 3'd1 : 3'd1;
                last_d = sbit;
                if (state_q != ST_CRC) crc_d = crc15_step(crc_q, sbit);
            end
        end

        if (take) begin
            unique case (state_q)
                ST_WAIT_IDLE: begin
                    if (!sbit) begin
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == 7'(IDLE_LEN - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (!sbit) begin
                        state_d    = ST_ARB;
                        bit_cnt_d  = '0;
                        run_d      = 3'd1;
                        last_d     = 1'b0;
                        crc_d      = '0;
                        arb_lost_d = '0;
                        data_sh_d  = '0;
                    end
                end
                ST_ARB: begin
                    arb_lost_d = arb_lost_q | (TXD & {NODES{~sbit}});
                    if (bit_cnt_q < 7'(ID_LEN)) begin
                        id_sh_d   = {id_sh_q[9:0], sbit};
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else begin
                        rtr_sh_d  = sbit;
                        bit_cnt_d = '0;
                        state_d   = ST_CTRL;
                    end
                end
                ST_CTRL: begin
                    if (bit_cnt_q == 7'd0 && sbit) begin
                        err_form_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                        bit_cnt_d  = '0;
                    end else begin
                        if (bit_cnt_q >= 7'd2) dlc_sh_d = dlc_next;
                        if (bit_cnt_q == 7'(CTRL_LEN - 1)) begin
                            bit_cnt_d = '0;
                            if (rtr_sh_q || dlc_next == 4'd0) begin
                                data_len_d = '0;
                                state_d    = ST_CRC;
                            end else begin
                                data_len_d = dlc_next[3] ? 7'd64 : {1'b0, dlc_next[2:0], 3'b000};
                                state_d    = ST_DATA;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                end
                ST_DATA: begin
                    // Bit k of the payload lands at position 63-k, i.e. ~k in six bits.
                    data_sh_d[~bit_cnt_q[5:0]] = sbit;
                    if (bit_cnt_q == data_len_q - 7'd1) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CRC;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                ST_CRC: begin
                    crc_rx_d = {crc_rx_q[13:0], sbit};
                    if (bit_cnt_q == 7'(CRC_LEN - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CRC_DEL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                ST_CRC_DEL: begin
                    if (crc_rx_q != crc_q) begin
                        err_crc_d = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else if (!sbit) begin
                        err_form_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_sh_d = ~sbit;
                    state_d  = ST_ACK_DEL;
                end
                ST_ACK_DEL: begin
                    bit_cnt_d = '0;
                    if (!sbit) begin
                        err_form_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (!sbit) begin
                        err_form_d = 1'b1;
                        state_d    = ST_WAIT_IDLE;
                        bit_cnt_d  = '0;
                    end else if (bit_cnt_q == 7'(EOF_LEN - 1)) begin
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 1'b1;
                        rx_id_d       = id_sh_q;
                        rx_rtr_d      = rtr_sh_q;
                        rx_dlc_d      = dlc_sh_q;
                        rx_data_d     = data_sh_q;
                        rx_ack_d      = ack_sh_q;
                        bit_cnt_d     = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                default: begin
                    state_d   = ST_WAIT_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge GCLK or negedge RES) begin
        if (!RES) begin
            state_q       <= ST_WAIT_IDLE;
            bit_cnt_q     <= '0;
            run_q         <= '0;
            last_q        <= 1'b1;
            crc_q         <= '0;
            crc_rx_q      <= '0;
            id_sh_q       <= '0;
            rtr_sh_q      <= 1'b0;
            dlc_sh_q      <= '0;
            data_sh_q     <= '0;
            ack_sh_q      <= 1'b0;
            data_len_q    <= '0;
            arb_lost_q    <= '0;
            rx_id_q       <= '0;
            rx_rtr_q      <= 1'b0;
            rx_dlc_q      <= '0;
            rx_data_q     <= '0;
            rx_ack_q      <= 1'b0;
            frame_cnt_q   <= '0;
            frame_valid_q <= 1'b0;
            err_stuff_q   <= 1'b0;
            err_crc_q     <= 1'b0;
            err_form_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            run_q         <= run_d;
            last_q        <= last_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            id_sh_q       <= id_sh_d;
            rtr_sh_q      <= rtr_sh_d;
            dlc_sh_q      <= dlc_sh_d;
            data_sh_q     <= data_sh_d;
            ack_sh_q      <= ack_sh_d;
            data_len_q    <= data_len_d;
            arb_lost_q    <= arb_lost_d;
            rx_id_q       <= rx_id_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_ack_q      <= rx_ack_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_valid_q <= frame_valid_d;
            err_stuff_q   <= err_stuff_d;
            err_crc_q     <= err_crc_d;
            err_form_q    <= err_form_d;
        end
    end

    assign rx_id       = rx_id_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign rx_ack      = rx_ack_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_stuff   = err_stuff_q;
    assign err_crc     = err_crc_q;
    assign err_form    = err_form_q;
    assign arb_lost    = arb_lost_q;

endmodule

// File: doc/can_bus_monitor.md
Name: can_bus_monitor

Overview:
Parametrised successor to the two-node CAN sandbox wiring. It forms the wired-AND CAN bus from NODES transmitter lines and generates its own bit timing, replacing the external clock divider. It also acts as a passive frame monitor. It destuffs and decodes standard (11-bit ID) CAN frames, checks stuffing, CRC-15 and form, reports per-node arbitration loss, and presents captured fields for display/LED logic.

Parameters:
NODES, 2, number of node TX lines wired onto the bus (1..8)
TBIT, 100, GCLK cycles per CAN bit (>= 8)
SAMPLE_PT, 70, bit-counter value at which the bus is sampled (1..TBIT-2)
FCNT_W, 16, width of the good-frame counter

Ports:
GCLK  in  1  system clock
RES  in  1  reset, asynchronous, active-low
TXD  in  NODES  node transmit lines, 1 = recessive
CAN_BUS  out  1  wired-AND of TXD (combinational), the bus seen by all nodes
bus_idle  out  1  high after 11 consecutive recessive sampled bits outside a frame
rx_id  out  11  identifier of last good frame
rx_rtr  out  1  RTR bit of last good frame
rx_dlc  out  4  DLC field as received
rx_data  out  64  data bytes, first byte in [63:56], unused bytes zero
rx_ack  out  1  ACK slot was dominant in last good frame
frame_valid  out  1  one-GCLK pulse on good frame
frame_cnt  out  FCNT_W  good-frame count, wraps to 0
err_stuff, err_crc, err_form  out  1 each  one-GCLK error pulses
arb_lost  out  NODES  per-node arbitration-loss flag, sticky until next SOF

Behaviour:
- Reset (RES=0, async): all outputs except CAN_BUS go to 0, state WAIT_IDLE, bit counter 0. A reset mid-frame discards the frame; no pulse is generated.
- Bit timing:
  - Counter runs 0..TBIT-1 and wraps.
  - Sample strobe fires when counter == SAMPLE_PT.
  - Hard sync: in IDLE, a 1->0 edge on CAN_BUS (registered) loads counter with 1. This is the SOF edge.
  - No soft resync.
- States and transitions:
  - WAIT_IDLE -> IDLE after 11 recessive samples. bus_idle=1 in IDLE.
  - IDLE: a dominant sample -> SOF; bus_idle=0; arb_lost cleared; CRC cleared; go to ARB.
  - ARB: 11 ID bits, MSB first, then RTR.
  - CTRL: IDE, r0, DLC[3:0]. IDE=1 (extended frame) -> err_form, go to WAIT_IDLE.
  - DATA: byte count = 0 if RTR=1, else min(DLC,8)*8 bits. If the count is 0, skip straight to CRC.
  - CRC: 15 bits.
  - CRC_DEL: a dominant bit -> err_form.
  - ACK: capture the sample into the ack bit.
  - ACK_DEL: a dominant bit -> err_form.
  - EOF: 7 recessive bits. Any dominant bit -> err_form.
  - After the 7th EOF bit: frame_valid pulses one GCLK after that sample strobe. Captured fields and frame_cnt+1 update in the same cycle. Go to IDLE directly; intermission is not enforced.
- Stuffing, from SOF through the last CRC bit:
  - After 5 equal consecutive destuffed-stream bits, the next sample is a stuff bit. It must differ from the previous bit, otherwise err_stuff and go to WAIT_IDLE.
  - The stuff bit is excluded from field decode and CRC. The run count restarts at 1 with the stuff bit's value.
  - No stuffing from CRC_DEL onward.
- CRC:
  - CRC-15, polynomial 0x4599, init 0, computed over destuffed SOF..last data bit.
  - If received CRC != computed: err_crc pulses at the CRC_DEL sample, go to WAIT_IDLE, no frame_valid.
- Any error pulse leaves all captured rx_* fields unchanged.
- Arbitration:
  - In ARB state, at each non-stuff sample, for every i with TXD[i]==1 while the sampled bus == 0, set arb_lost[i].
  - Flags hold until the next SOF. Simultaneous loss by several nodes sets all of their bits.
- Captured fields are double-buffered: decode uses shadow registers, and the outputs copy them only on frame_valid.
- DLC values 9..15 are reported raw in rx_dlc, but 8 bytes are received.

Decomposition:
- Package can_pkg:
  - state encoding
  - CRC15_POLY = 15'h4599
  - field lengths (ID_LEN 11, DLC_LEN 4, CRC_LEN 15, EOF_LEN 7, IDLE_LEN 11)
  - stuff limit 5
- Sub-module can_bit_timing (parameters TBIT, SAMPLE_PT):
  - inputs GCLK, RES, bus, hsync_en
  - outputs sample strobe and sampled bit
- The FSM, destuffer and CRC stay in can_bus_monitor.

Test Plan:
1. Release reset with all TXD=1 for 11 bit times -> bus_idle=1 no later than 11*TBIT+SAMPLE_PT cycles; no error pulses.
2. Node0 sends ID 0x123, RTR 0, DLC 2, data 0xA5 0x5A, with correct stuff bits and CRC; node1 drives the ACK slot dominant -> one frame_valid pulse; rx_id=0x123, rx_dlc=2, rx_data=64'hA55A000000000000, rx_ack=1, frame_cnt=1.
3. Both nodes SOF in the same bit: node0 ID 0x100, node1 ID 0x0FF, and each node stops driving after its lost bit -> arb_lost=2'b01; rx_id=0x0FF; frame_cnt increments once.
4. Six consecutive dominant bits inside the ID -> err_stuff pulses once; no frame_valid; bus_idle returns only after 11 recessive bits.
5. Clean frame with one CRC bit inverted (stuffing kept legal) -> err_crc at CRC_DEL; rx_* unchanged from the prior frame; frame_cnt unchanged.
6. Assert RES for 3 cycles mid-DATA -> all outputs 0 immediately; the following clean frame (ID 0x7FF, RTR 1, DLC 0) is decoded with frame_cnt=1 and rx_data=0.
